alu_serial_seq: RTL and testbench

Bit-serial sequencer that runs WIDTH-bit operations through the 1-bit ALU slice, one bit per clock, LSB first. It sits on both sides of the slice. Upstream, it accepts a word-level operation over a valid/ready handshake and drives the slice's A, B, Cin and S inputs. Downstream, it consumes the slice's f and Cout, chains Cout back into Cin and assembles the WIDTH-bit result for a valid/ready consumer.

---
 rtl/alu_serial_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_serial_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: runs WIDTH-bit ops LSB-first through a 1-bit ALU slice.
// Define ALU_SERIAL_SEQ_OVF_EN to add the out_ovf overflow port.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_s,
  input  logic             alu_f,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cout,
  output logic             out_err
`ifdef ALU_SERIAL_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
`ifdef ALU_SERIAL_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic arith;
  logic is_inc;
  logic last;
  logic rsvd;

  assign is_inc = (op_q == 3'd5);
  assign arith  = (op_q == 3'd4) || is_inc;
  assign last   = (cnt_q == CW'(WIDTH-1));
  assign rsvd   = (in_op > 3'd5);

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    res_d     = res_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    cout_d    = cout_q;
    err_d     = err_q;
`ifdef ALU_SERIAL_SEQ_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = 1'b0;
    alu_b     = 1'b0;
    alu_cin   = 1'b0;
    alu_s     = 4'b0000;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sr_d  = in_a;
          b_sr_d  = in_b;
          op_d    = in_op;
          cnt_d   = '0;
          c_d     = (in_op == 3'd5);
          res_d   = '0;
          cout_d  = 1'b0;
          err_d   = rsvd;
`ifdef ALU_SERIAL_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = rsvd ? DONE : RUN;
        end
      end
      RUN: begin
        alu_a   = a_sr_q[0];
        alu_b   = is_inc ? 1'b0 : b_sr_q[0];
        alu_cin = c_q;
        unique case (1'b1)
          op_q == 3'd0: alu_s = 4'b0000;
          op_q == 3'd1: alu_s = 4'b0001;
          op_q == 3'd2: alu_s = 4'b0010;
          op_q == 3'd3: alu_s = 4'b0011;
          default:      alu_s = 4'b0100;
        endcase
        res_d  = {alu_f, res_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        c_d    = arith & alu_cout;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          // MSB cycle: capture final carry and signed overflow
          cout_d  = arith & alu_cout;
`ifdef ALU_SERIAL_SEQ_OVF_EN
          ovf_d   = arith & (c_q ^ alu_cout);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SERIAL_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef ALU_SERIAL_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_f    = res_q;
  assign out_cout = cout_q;
  assign out_err  = err_q;
`ifdef ALU_SERIAL_SEQ_OVF_EN
  assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: scoreboard bench for alu_serial_seq with a
// behavioural 1-bit slice and a word-level arithmetic reference.
module tb_alu_serial_seq;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] f;
    logic         cout;
    logic         err;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         alu_a;
  logic         alu_b;
  logic         alu_cin;
  logic [3:0]   alu_s;
  logic         alu_f;
  logic         alu_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_f;
  logic         out_cout;
  logic         out_err;
`ifdef ALU_SERIAL_SEQ_OVF_EN
  logic         out_ovf;
`endif

  exp_t exp_q[$];
  int   tests;
  int   fails;
  bit   rnd;
  bit   chk_b0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_s     (alu_s),
    .alu_f     (alu_f),
    .alu_cout  (alu_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_cout  (out_cout),
    .out_err   (out_err)
`ifdef ALU_SERIAL_SEQ_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit ALU slice the sequencer drives
  always_comb begin
    alu_f    = 1'b0;
    alu_cout = 1'b0;
    case (alu_s)
      4'b0000: alu_f = alu_a & alu_b;
      4'b0001: alu_f = alu_a | alu_b;
      4'b0010: alu_f = alu_a ^ alu_b;
      4'b0011: alu_f = alu_a;
      4'b0100: begin
        alu_f    = alu_a ^ alu_b ^ alu_cin;
        alu_cout = (alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b));
      end
      default: alu_f = 1'b0;
    endcase
  end

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] bb;
    e.f = '0; e.cout = 1'b0; e.err = 1'b0; e.ovf = 1'b0;
    case (op)
      3'd0: e.f = a & b;
      3'd1: e.f = a | b;
      3'd2: e.f = a ^ b;
      3'd3: e.f = a;
      3'd4, 3'd5: begin
        bb     = (op == 3'd5) ? W'(1) : b;
        s      = {1'b0, a} + {1'b0, bb};
        e.f    = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (e.f[W-1] != a[W-1]);
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(n), 32'(0));
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_op    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input string nm, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      if (chk_b0) chk("inc_alu_b_zero", 32'(alu_b), 32'(0));
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk(nm, 32'(n), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    tests     = 0;
    fails     = 0;
    rnd       = 1'b0;
    chk_b0    = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(out_f), 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("sb_f", 32'(out_f), 32'(e.f));
            chk("sb_cout", 32'(out_cout), 32'(e.cout));
            chk("sb_err", 32'(out_err), 32'(e.err));
`ifdef ALU_SERIAL_SEQ_OVF_EN
            chk("sb_ovf", 32'(out_ovf), 32'(e.ovf));
`endif
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_f", 32'(out_f), 32'(0));
    chk("rst_out_cout", 32'(out_cout), 32'(0));
    chk("rst_out_err", 32'(out_err), 32'(0));
    chk("rst_alu", 32'({alu_a, alu_b, alu_cin, alu_s}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    issue(3'd4, 8'hFF, 8'h01); wait_done("lat_add_ff", 8);
    issue(3'd4, 8'h7F, 8'h01); wait_done("lat_add_7f", 8);
    issue(3'd0, 8'hF0, 8'h3C); wait_done("lat_and", 8);
    issue(3'd1, 8'hF0, 8'h3C); wait_done("lat_or", 8);
    issue(3'd2, 8'hF0, 8'h3C); wait_done("lat_xor", 8);
    issue(3'd3, 8'hA5, 8'h5A); wait_done("lat_pass", 8);
    issue(3'd5, 8'hFF, 8'hFF); wait_done("lat_inc_ff", 8);
    chk_b0 = 1'b1;
    issue(3'd5, 8'h41, 8'hFF); wait_done("lat_inc_41", 8);
    chk_b0 = 1'b0;

    // stall: result must hold while out_ready is low
    out_ready = 1'b0;
    issue(3'd4, 8'h12, 8'h34);
    wait_done("lat_add_stall", 8);
    in_valid = 1'b1;
    in_op    = 3'd1;
    in_a     = 8'h11;
    in_b     = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'(1));
      chk("stall_f", 32'(out_f), 32'h46);
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // reset in the 4th RUN cycle aborts the op
    issue(3'd4, 8'h55, 8'h66);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_out_f", 32'(out_f), 32'(0));
    chk("abort_cout_err", 32'({out_cout, out_err}), 32'(0));
    chk("abort_alu", 32'({alu_a, alu_b, alu_cin, alu_s}), 32'(0));
    @(posedge clk); #1;
    issue(3'd6, 8'hAB, 8'hCD);
    wait_done("lat_reserved", 0);

    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
    rnd       = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
